// File: rtl/tinyml_mem_pkg.sv
// rtl/tinyml_mem_pkg.sv - shared memory-path widths, store FSM state type and tile sizing helper
package tinyml_mem_pkg;
  localparam int ADDR_WIDTH  = 24;
  localparam int LEN_WIDTH   = 20;
  localparam int TOTAL_WIDTH = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TILE,
    ST_WRITING,
    ST_DONE
  } store_state_t;

  function automatic int bytes_per_tile(input int tile_width);
    return tile_width / 8;
  endfunction
endpackage

// File: rtl/store_m.sv
// rtl/store_m.sv - serializes result tiles into byte writes at consecutive memory addresses
// Optional STORE_M_ZERO_PAD_EN: write zeros into the unused tail of the final tile.
module store_m
  import tinyml_mem_pkg::*;
#(
  parameter int TILE_WIDTH = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [TILE_WIDTH-1:0] tile_in,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  output logic                  tile_out,
  output logic                  valid_out,
  output logic                  busy
);
  localparam int NUM_BYTES       = bytes_per_tile(TILE_WIDTH);
  localparam int CNT_W           = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BYTES_PER_VALUE = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  store_state_t           r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [TOTAL_WIDTH-1:0] r_rem;
  logic [TILE_WIDTH-1:0]  r_tile;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic                   r_tile_out;
  logic                   r_valid_out;

  logic [TOTAL_WIDTH-1:0] w_total;
  logic                   w_in_range;
  logic                   w_we;
  logic [7:0]             w_byte;

  assign w_total    = TOTAL_WIDTH'(length) * TOTAL_WIDTH'(BYTES_PER_VALUE);
  assign w_in_range = (r_rem != '0);
  assign w_byte     = r_tile[8*r_byte_cnt +: 8];

`ifdef STORE_M_ZERO_PAD_EN
  assign w_we = (r_state == ST_WRITING);
`else
  assign w_we = (r_state == ST_WRITING) && w_in_range;
`endif

  // Padding slots carry zero data; outside writes the bus idles at zero.
  assign mem_din    = (w_we && w_in_range) ? w_byte : 8'h00;
  assign mem_we     = w_we;
  assign mem_addr   = r_addr;
  assign tile_ready = (r_state == ST_WAIT_TILE);
  assign busy       = (r_state != ST_IDLE);
  assign tile_out   = r_tile_out;
  assign valid_out  = r_valid_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_tile      <= '0;
      r_byte_cnt  <= '0;
      r_tile_out  <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_tile_out  <= 1'b0;
      r_valid_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_addr  <= dram_addr;
            r_rem   <= w_total;
            r_state <= (w_total == '0) ? ST_DONE : ST_WAIT_TILE;
          end
        end
        ST_WAIT_TILE: begin
          if (tile_valid) begin
            r_tile     <= tile_in;
            r_byte_cnt <= '0;
            r_state    <= ST_WRITING;
          end
        end
        ST_WRITING: begin
          if (w_we)       r_addr <= r_addr + 1'b1;
          if (w_in_range) r_rem  <= r_rem - 1'b1;
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (r_byte_cnt == LAST_BYTE) begin
            r_tile_out <= 1'b1;
            if (r_rem > TOTAL_WIDTH'(1)) begin
              r_state <= ST_WAIT_TILE;
            end else begin
              r_state     <= ST_DONE;
              r_valid_out <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Exit from WRITING already raised valid_out; the empty-transfer path raises it here instead.
          r_valid_out <= !r_valid_out;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_m.sv
// tb/tb_store_m.sv - directed self-checking bench for store_m
module tb_store_m;
  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [23:0]  dram_addr;
  logic [19:0]  length;
  logic [255:0] tile_in;
  logic         tile_valid;
  logic         tile_ready;
  logic         mem_we;
  logic [23:0]  mem_addr;
  logic [7:0]   mem_din;
  logic         tile_out;
  logic         valid_out;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_tile_out, n_valid_out, n_ready;
  int last_tile_out_cyc, last_valid_out_cyc;
  int s, ta, tb;
  logic [23:0] wa[$];
  logic [7:0]  wd[$];
  logic [23:0] ea[$];
  logic [7:0]  ed[$];

  store_m #(.TILE_WIDTH(256), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .dram_addr(dram_addr),
    .length(length), .tile_in(tile_in), .tile_valid(tile_valid),
    .tile_ready(tile_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .tile_out(tile_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
    end
    if (tile_out)   begin n_tile_out++;  last_tile_out_cyc  = cyc; end
    if (valid_out)  begin n_valid_out++; last_valid_out_cyc = cyc; end
    if (tile_ready) n_ready++;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); ea.delete(); ed.delete();
    n_tile_out = 0; n_valid_out = 0; n_ready = 0;
    last_tile_out_cyc = -1; last_valid_out_cyc = -1;
  endtask

  function automatic logic [255:0] mk_tile(input logic [7:0] base);
    logic [255:0] t;
    for (int i = 0; i < 32; i++) t[8*i +: 8] = base + 8'(i);
    return t;
  endfunction

  task automatic start(input logic [23:0] addr, input logic [19:0] len, output int s_cyc);
    s_cyc     = cyc;
    valid_in  = 1'b1;
    dram_addr = addr;
    length    = len;
    step();
    valid_in  = 1'b0;
    dram_addr = '0;
    length    = '0;
  endtask

  task automatic send_tile(input logic [255:0] data, output int t_cyc);
    int guard = 0;
    tile_in    = data;
    tile_valid = 1'b1;
    while (!tile_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("ready_wait", {31'b0, tile_ready}, 32'd1);
    t_cyc = cyc;
    step();
    tile_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), {8'b0, wa[i]}, {8'b0, ea[i]});
        chk($sformatf("%s_data%0d", tag, i), {24'b0, wd[i]}, {24'b0, ed[i]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; dram_addr = '0; length = '0;
    tile_in = '0; tile_valid = 1'b0;
    clear_log();
    step(); step();
    chk("rst_tile_ready", {31'b0, tile_ready}, 32'd0);
    chk("rst_mem_we",     {31'b0, mem_we},     32'd0);
    chk("rst_mem_addr",   {8'b0, mem_addr},    32'd0);
    chk("rst_mem_din",    {24'b0, mem_din},    32'd0);
    chk("rst_tile_out",   {31'b0, tile_out},   32'd0);
    chk("rst_valid_out",  {31'b0, valid_out},  32'd0);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    rst = 1'b0;
    step();

    // Single full tile
    clear_log();
    start(24'h000100, 20'd32, s);
    chk("t1_ready_s1", {31'b0, tile_ready}, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    send_tile(mk_tile(8'h00), ta);
    chk("t1_handshake_cyc", ta, s + 1);
    repeat (32) step();
    chk("t1_tile_out_cyc", last_tile_out_cyc, ta + 33);
    chk("t1_valid_out_cyc", last_valid_out_cyc, ta + 33);
    step();
    chk("t1_idle", {31'b0, busy}, 32'd0);
    chk("t1_valid_out_cnt", n_valid_out, 32'd1);
    for (int i = 0; i < 32; i++) begin ea.push_back(24'h000100 + 24'(i)); ed.push_back(8'(i)); end
    check_writes("t1");

    // Two tiles, partial second tile
    clear_log();
    start(24'h000200, 20'd40, s);
    send_tile(mk_tile(8'h40), ta);
    repeat (32) step();
    chk("t2_tile_ready_back", {31'b0, tile_ready}, 32'd1);
    send_tile(mk_tile(8'h80), tb);
    chk("t2_throughput", tb, ta + 33);
    repeat (32) step();
    chk("t2_tile_out_cnt", n_tile_out, 32'd2);
    chk("t2_valid_out_cyc", last_valid_out_cyc, tb + 33);
    step();
    for (int i = 0; i < 32; i++) begin ea.push_back(24'h000200 + 24'(i)); ed.push_back(8'h40 + 8'(i)); end
    for (int i = 0; i < 8; i++)  begin ea.push_back(24'h000220 + 24'(i)); ed.push_back(8'h80 + 8'(i)); end
`ifdef STORE_M_ZERO_PAD_EN
    for (int i = 8; i < 32; i++) begin ea.push_back(24'h000220 + 24'(i)); ed.push_back(8'h00); end
`endif
    check_writes("t2");

    // Zero length
    clear_log();
    start(24'h000300, 20'd0, s);
    chk("z_busy", {31'b0, busy}, 32'd1);
    step();
    chk("z_valid_out_s2", {31'b0, valid_out}, 32'd1);
    step();
    chk("z_valid_out_low", {31'b0, valid_out}, 32'd0);
    chk("z_valid_out_cyc", last_valid_out_cyc, s + 2);
    chk("z_no_ready", n_ready, 32'd0);
    check_writes("z");

    // Address wrap
    clear_log();
    start(24'hFFFFF0, 20'd32, s);
    send_tile(mk_tile(8'hA0), ta);
    repeat (33) step();
    chk("w_valid_out_cnt", n_valid_out, 32'd1);
    for (int i = 0; i < 32; i++) begin ea.push_back(24'hFFFFF0 + 24'(i)); ed.push_back(8'hA0 + 8'(i)); end
    check_writes("w");

    // Stalled second tile with a stray valid_in while busy
    clear_log();
    start(24'h000300, 20'd64, s);
    send_tile(mk_tile(8'hC0), ta);
    repeat (32) step();
    valid_in = 1'b1; dram_addr = 24'h000999; length = 20'd5;
    step();
    valid_in = 1'b0; dram_addr = '0; length = '0;
    repeat (4) step();
    chk("s_no_writes_stalled", wa.size(), 32'd32);
    chk("s_still_ready", {31'b0, tile_ready}, 32'd1);
    send_tile(mk_tile(8'hE0), tb);
    chk("s_handshake_cyc", tb, ta + 38);
    repeat (32) step();
    chk("s_valid_out_cyc", last_valid_out_cyc, tb + 33);
    n_ready = 0;
    repeat (3) step();
    chk("s_stray_ignored_ready", n_ready, 32'd0);
    chk("s_stray_ignored_busy", {31'b0, busy}, 32'd0);
    chk("s_valid_out_cnt", n_valid_out, 32'd1);
    for (int i = 0; i < 32; i++) begin ea.push_back(24'h000300 + 24'(i)); ed.push_back(8'hC0 + 8'(i)); end
    for (int i = 0; i < 32; i++) begin ea.push_back(24'h000320 + 24'(i)); ed.push_back(8'hE0 + 8'(i)); end
    check_writes("s");

    // Reset during byte 10
    clear_log();
    start(24'h000400, 20'd32, s);
    send_tile(mk_tile(8'h10), ta);
    repeat (10) step();
    chk("r_byte10_addr", {8'b0, mem_addr}, 32'h00040A);
    chk("r_byte10_data", {24'b0, mem_din}, 32'h1A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_mem_we_off", {31'b0, mem_we}, 32'd0);
    chk("r_busy_off", {31'b0, busy}, 32'd0);
    n_tile_out = 0; n_valid_out = 0;
    repeat (40) step();
    chk("r_no_tile_out", n_tile_out, 32'd0);
    chk("r_no_valid_out", n_valid_out, 32'd0);
    clear_log();
    start(24'h000500, 20'd8, s);
    send_tile(mk_tile(8'h55), ta);
    repeat (32) step();
    chk("r_after_tile_out_cyc", last_tile_out_cyc, ta + 33);
    chk("r_after_valid_out_cyc", last_valid_out_cyc, ta + 33);
    step();
    for (int i = 0; i < 8; i++) begin ea.push_back(24'h000500 + 24'(i)); ed.push_back(8'h55 + 8'(i)); end
`ifdef STORE_M_ZERO_PAD_EN
    for (int i = 8; i < 32; i++) begin ea.push_back(24'h000500 + 24'(i)); ed.push_back(8'h00); end
`endif
    check_writes("r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
